// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolve unit:
//   - funct3 encodings of the six conditional branches
//   - the two funct3 codes that are not branches (ILLEGAL classification)
//   - packed compare-flag record passed from the comparator into stage 1
//   - helper functions for illegal classification and direction decode
// -----------------------------------------------------------------------------
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct3 values inside the branch opcode space that do not name a branch
  localparam logic [2:0] F3_ILLEGAL_A = 3'b010;
  localparam logic [2:0] F3_ILLEGAL_B = 3'b011;

  typedef struct packed {
    logic eq;
    logic lt;
    logic ltu;
  } cmp_flags_t;

  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == F3_ILLEGAL_A) || (f3 == F3_ILLEGAL_B);
  endfunction

  // Illegal codes resolve as not-taken so the redirect falls through to pc+4.
  function automatic logic resolve_taken(input logic [2:0] f3, input cmp_flags_t fl);
    logic t;
    case (f3)
      F3_BEQ:  t = fl.eq;
      F3_BNE:  t = !fl.eq;
      F3_BLT:  t = fl.lt;
      F3_BGE:  t = !fl.lt;
      F3_BLTU: t = fl.ltu;
      F3_BGEU: t = !fl.ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// -----------------------------------------------------------------------------
// branch_compare
// Purely combinational full-width operand comparator.
// Ports:
//   a, b  in  XLEN  operands (rs1, rs2)
//   eq    out 1     a == b
//   lt    out 1     signed a < signed b
//   ltu   out 1     unsigned a < unsigned b
// -----------------------------------------------------------------------------
module branch_compare #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Two-stage valid/ready pipeline that resolves conditional branches.
//   S1: captures funct3/pc/imm/prediction and the eq/lt/ltu compare flags.
//   S2: the output registers -- direction, redirect PC and status flags.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake
//   in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken   branch op
//   flush                    drops every op in flight at the next edge
//   out_valid/out_ready      output handshake
//   out_taken, out_redirect_pc, out_mispredict, out_misaligned, out_illegal
//   branch_count, mispredict_count   saturating retire counters
// -----------------------------------------------------------------------------
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_redirect_pc,
  output logic             out_mispredict,
  output logic             out_misaligned,
  output logic             out_illegal,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(3'd4);

  logic             s1_valid;
  logic [2:0]       s1_funct3;
  logic [XLEN-1:0]  s1_pc;
  logic [XLEN-1:0]  s1_imm;
  logic             s1_pred;
  cmp_flags_t       s1_flags;

  logic             cmp_eq, cmp_lt, cmp_ltu;
  logic             s2_ready, s1_advance, accept, retire;
  logic             taken_c, illegal_c, misaligned_c, mispredict_c;
  logic [XLEN-1:0]  target_c, pc4_c, redirect_c;

  branch_compare #(.XLEN(XLEN)) u_compare (
    .a   (in_rs1),
    .b   (in_rs2),
    .eq  (cmp_eq),
    .lt  (cmp_lt),
    .ltu (cmp_ltu)
  );

  // S2 can take a new op when it is empty or its result leaves this cycle.
  assign s2_ready   = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_ready;
  // Depends only on state, flush and rst -- never on in_valid.
  assign in_ready   = !rst && !flush && (!s1_valid || s2_ready);
  assign accept     = in_valid && in_ready;
  assign retire     = out_valid && out_ready;

  // Stage 1: capture the offered op together with its compare flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_funct3 <= 3'b000;
      s1_pc     <= '0;
      s1_imm    <= '0;
      s1_pred   <= 1'b0;
      s1_flags  <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_funct3 <= in_funct3;
      s1_pc     <= in_pc;
      s1_imm    <= in_imm;
      s1_pred   <= in_pred_taken;
      s1_flags  <= '{eq: cmp_eq, lt: cmp_lt, ltu: cmp_ltu};
    end else if (s1_advance) begin
      s1_valid  <= 1'b0;
    end
  end

  // Resolve direction, redirect address and status flags from the S1 op.
  always_comb begin
    illegal_c    = is_illegal(s1_funct3);
    taken_c      = resolve_taken(s1_funct3, s1_flags);
    target_c     = s1_pc + s1_imm;
    pc4_c        = s1_pc + PC_STEP;
    if (taken_c) begin
      redirect_c = target_c;
    end else begin
      redirect_c = pc4_c;
    end
    misaligned_c = taken_c && (target_c[1:0] != 2'b00);
    mispredict_c = !illegal_c && (taken_c != s1_pred);
  end

  // Stage 2: output registers; hold every field while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_taken       <= 1'b0;
      out_redirect_pc <= '0;
      out_mispredict  <= 1'b0;
      out_misaligned  <= 1'b0;
      out_illegal     <= 1'b0;
    end else if (flush) begin
      out_valid       <= 1'b0;
    end else if (s2_ready) begin
      out_valid       <= s1_valid;
      if (s1_valid) begin
        out_taken       <= taken_c;
        out_redirect_pc <= redirect_c;
        out_mispredict  <= mispredict_c;
        out_misaligned  <= misaligned_c;
        out_illegal     <= illegal_c;
      end
    end
  end

  // Saturating retire counters; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (retire) begin
      if (!out_illegal && (branch_count != CNT_MAX)) begin
        branch_count <= branch_count + CNT_ONE;
      end
      if (out_mispredict && (mispredict_count != CNT_MAX)) begin
        mispredict_count <= mispredict_count + CNT_ONE;
      end
    end
  end

endmodule
